// File: rtl/dac_pair_feed_pkg.sv
// dac_feed_pkg: shared constants, FSM state type and sample conversion for
// the DAC pair feeder.
//   DAC_W          sample width of one DAC half-cycle
//   MIDSCALE       offset-binary zero level driven while idle or starved
//   state_t        feeder FSM states
//   to_offset_bin  two's-complement to offset-binary (MSB invert)
package dac_feed_pkg;

    localparam int unsigned DAC_W = 14;
    localparam logic [DAC_W-1:0] MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    function automatic logic [DAC_W-1:0] to_offset_bin(input logic [DAC_W-1:0] s);
        return {~s[DAC_W-1], s[DAC_W-2:0]};
    endfunction

endpackage

// File: rtl/dac_pair_feed_if.sv
// dac_pair_feed_if: valid/ready sample-pair stream into the DAC feeder.
//   in_valid  producer has a pair
//   in_ready  feeder accepts a pair this cycle
//   in_d0     two's-complement sample, first half-cycle
//   in_d1     two's-complement sample, second half-cycle
// Modports: master (producer side), slave (feeder side).
interface dac_pair_feed_if;
    import dac_feed_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DAC_W-1:0] in_d0;
    logic [DAC_W-1:0] in_d1;

    modport master (output in_valid, in_d0, in_d1, input in_ready);
    modport slave  (input in_valid, in_d0, in_d1, output in_ready);

endinterface

// File: rtl/dac_pair_feed_fifo.sv
// dac_pair_fifo: synchronous first-word-fall-through FIFO for sample pairs.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous empty (overrides push/pop)
//   push, wdata write an entry (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   rdata       head entry, valid while not empty
//   count       registered occupancy; full/empty derived from it
module dac_pair_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned W          = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push,
    input  logic [W-1:0]        wdata,
    input  logic                pop,
    output logic [W-1:0]        rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dac_pair_feed.sv
// dac_pair_feed: sample-pair feeder for the 14-bit DDR DAC output cells.
// Buffers two's-complement pairs, primes the FIFO full before streaming,
// and presents one registered offset-binary pair per clock.
//   clk, rst_n      DAC clock, asynchronous active-low reset
//   enable          1 = stream, 0 = idle and flush
//   bus             slave side of the input pair stream
//   pattern_sel     select internal ramp (only with DAC_FEED_PATTERN_EN)
//   cnt_clr         synchronous clear of underrun_count
//   data0, data1    offset-binary samples to output cells D1/D2
//   underrun        one-cycle pulse per starved RUN cycle
//   underrun_count  saturating count of underruns
//   running         high in RUN
// Optional build macro: DAC_FEED_PATTERN_EN (ramp test pattern).
module dac_pair_feed
    import dac_feed_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned UCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    dac_pair_feed_if.slave    bus,
    input  logic              pattern_sel,
    input  logic              cnt_clr,
    output logic [DAC_W-1:0]  data0,
    output logic [DAC_W-1:0]  data1,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_count,
    output logic              running
);

    state_t                 state_q, state_d;
    logic                   flush, push, pop, starve, inc;
    logic                   run_active, pat_mode;
    logic [DEPTH_LOG2:0]    fifo_count;
    logic                   fifo_full, fifo_empty;
    logic [2*DAC_W-1:0]     fifo_rdata, pair_q;
    logic                   pop_q, starve_q;

    dac_pair_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (2*DAC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata ({bus.in_d0, bus.in_d1}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready depends only on registered state and count, never on pop.
    assign bus.in_ready = (state_q != IDLE) && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign running      = (state_q == RUN);
    assign run_active   = (state_q == RUN) && enable;
    assign pop          = run_active && !pat_mode && !fifo_empty;
    assign starve       = run_active && !pat_mode && fifo_empty;
    assign inc          = run_active && !pat_mode && starve_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                flush = 1'b1;
                if (enable) state_d = PRIME;
            end
            // Enter RUN on the edge that fills the FIFO.
            PRIME: begin
                if (fifo_full || (push && fifo_count == {1'b0, {DEPTH_LOG2{1'b1}}}))
                    state_d = RUN;
            end
            RUN: state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            flush   = 1'b1;
        end
    end

`ifdef DAC_FEED_PATTERN_EN
    logic [DAC_W-1:0] ramp_q;

    assign pat_mode = pattern_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ramp_q <= '0;
        else if (state_q == IDLE || !enable) ramp_q <= '0;
        else if (run_active && pat_mode)     ramp_q <= ramp_q + 14'd2;
    end
`else
    logic pattern_unused;

    assign pat_mode       = 1'b0;
    assign pattern_unused = pattern_sel;
`endif

    // Two-stage output: the popped pair (or starvation flag) is staged one
    // clock, then converted into the output registers on the next edge.
    // A staged pair is discarded if the ramp takes over in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q   <= '0;
            pop_q    <= 1'b0;
            starve_q <= 1'b0;
            data0    <= MIDSCALE;
            data1    <= MIDSCALE;
            underrun <= 1'b0;
        end else begin
            pop_q    <= pop;
            starve_q <= starve;
            if (pop) pair_q <= fifo_rdata;
            data0    <= MIDSCALE;
            data1    <= MIDSCALE;
            underrun <= inc;
            if (run_active) begin
`ifdef DAC_FEED_PATTERN_EN
                if (pat_mode) begin
                    data0 <= ramp_q;
                    data1 <= ramp_q + 14'd1;
                end else
`endif
                if (pop_q) begin
                    data0 <= to_offset_bin(pair_q[2*DAC_W-1:DAC_W]);
                    data1 <= to_offset_bin(pair_q[DAC_W-1:0]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          underrun_count <= '0;
        else if (cnt_clr)                    underrun_count <= '0;
        else if (inc && underrun_count != '1) underrun_count <= underrun_count + 1'b1;
    end

endmodule

// File: tb/tb_dac_pair_feed.sv
// tb_dac_pair_feed: self-checking bench for dac_pair_feed. Expected output
// pairs are queued when pushes are driven and popped when the DUT should
// present them. Underrun counter uses a narrow width to reach saturation.
module tb_dac_pair_feed;
    import dac_feed_pkg::*;

    localparam int unsigned UW = 4;

    typedef struct packed {
        logic [13:0] d0;
        logic [13:0] d1;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          pattern_sel = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [13:0]   data0, data1;
    logic          underrun;
    logic [UW-1:0] underrun_count;
    logic          running;

    int    checks = 0;
    int    errors = 0;
    pair_t exp_q[$];

    dac_pair_feed_if bus ();

    dac_pair_feed #(
        .DEPTH_LOG2 (2),
        .UCNT_W     (UW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .bus            (bus),
        .pattern_sel    (pattern_sel),
        .cnt_clr        (cnt_clr),
        .data0          (data0),
        .data1          (data1),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .running        (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_pair(input int a, input int b);
        pair_t e;
        bus.in_valid = 1'b1;
        bus.in_d0    = 14'(a);
        bus.in_d1    = 14'(b);
        e.d0 = 14'(a + 8192);
        e.d1 = 14'(b + 8192);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        enable       = 1'b0;
        pattern_sel  = 1'b0;
        cnt_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_d0    = '0;
        bus.in_d1    = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enable and push four pairs; returns at the negedge after the 4th push.
    task automatic enter_run(input int base);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_pair(base + 2 * i, base + 2 * i + 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({data0, data1, underrun, underrun_count, running, bus.in_ready} !==
            {MIDSCALE, MIDSCALE, 1'b0, UW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: d0=%h d1=%h ur=%b cnt=%0d run=%b rdy=%b, expected 2000 2000 0 0 0 0",
                     data0, data1, underrun, underrun_count, running, bus.in_ready);
        end
    endtask

    task automatic test_stream();
        int s0[10] = '{0, 2, 4, 6, -8192, 8191, -1, 100, -4000, 1234};
        int s1[10] = '{1, 3, 5, 7, 8191, -8192, 0, -100, 4000, -1};
        int nxt;
        pair_t e;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL prime_ready: in_ready=%b expected 1", bus.in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            drive_pair(s0[i], s1[i]);
            @(negedge clk);
            checks++;
            if (running !== (i == 3)) begin
                errors++;
                $display("FAIL prime_running push %0d: running=%b expected %b", i, running, (i == 3));
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: in_ready=%b expected 0", bus.in_ready);
        end
        nxt = 4;
        for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
            if (c >= 2) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready c=%0d: in_ready=%b expected 1", c, bus.in_ready);
                end
            end
            if (bus.in_ready && nxt < 10) begin
                drive_pair(s0[nxt], s1[nxt]);
                nxt++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (c == 1) begin
                if ({data0, data1, underrun} !== {MIDSCALE, MIDSCALE, 1'b0}) begin
                    errors++;
                    $display("FAIL stream_fill: got %h/%h ur=%b expected 2000/2000 ur=0", data0, data1, underrun);
                end
            end else begin
                e = exp_q.pop_front();
                if ({data0, data1, underrun} !== {e.d0, e.d1, 1'b0}) begin
                    errors++;
                    $display("FAIL stream c=%0d: got %h/%h ur=%b expected %h/%h ur=0",
                             c, data0, data1, underrun, e.d0, e.d1);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout: %0d pairs left, expected 0", exp_q.size());
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({data0, data1, underrun, underrun_count, running, bus.in_ready} !==
            {MIDSCALE, MIDSCALE, 1'b0, UW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stream_stop: d0=%h d1=%h ur=%b cnt=%0d run=%b rdy=%b, expected 2000 2000 0 0 0 0",
                     data0, data1, underrun, underrun_count, running, bus.in_ready);
        end
    endtask

    task automatic test_underrun();
        pair_t e;
        do_reset();
        enter_run(10);
        for (int c = 1; c <= 10; c++) begin
            bus.in_valid = 1'b0;
            if (c == 7) drive_pair(500, -500);
            if (c == 10) enable = 1'b0;
            @(negedge clk);
            checks++;
            if ((c >= 2 && c <= 5) || c == 9) begin
                e = exp_q.pop_front();
                if ({data0, data1, underrun} !== {e.d0, e.d1, 1'b0}) begin
                    errors++;
                    $display("FAIL underrun_data c=%0d: got %h/%h ur=%b expected %h/%h ur=0",
                             c, data0, data1, underrun, e.d0, e.d1);
                end
            end else if (c >= 6 && c <= 8) begin
                if ({data0, data1, underrun, underrun_count} !== {MIDSCALE, MIDSCALE, 1'b1, UW'(c - 5)}) begin
                    errors++;
                    $display("FAIL underrun_gap c=%0d: got %h/%h ur=%b cnt=%0d expected 2000/2000 ur=1 cnt=%0d",
                             c, data0, data1, underrun, underrun_count, c - 5);
                end
            end else begin
                if ({data0, data1, underrun} !== {MIDSCALE, MIDSCALE, 1'b0}) begin
                    errors++;
                    $display("FAIL underrun_mid c=%0d: got %h/%h ur=%b expected 2000/2000 ur=0",
                             c, data0, data1, underrun);
                end
            end
        end
        checks++;
        if ({underrun_count, running} !== {UW'(3), 1'b0}) begin
            errors++;
            $display("FAIL underrun_total: cnt=%0d run=%b expected cnt=3 run=0", underrun_count, running);
        end
    endtask

    task automatic test_counter();
        int exp_cnt;
        do_reset();
        enter_run(40);
        exp_q.delete();
        for (int c = 1; c <= 30; c++) begin
            cnt_clr = (c == 8);
            @(negedge clk);
            if (c < 6)      exp_cnt = 0;
            else if (c < 8) exp_cnt = c - 5;
            else            exp_cnt = (c - 8 > 15) ? 15 : c - 8;
            checks++;
            if ({underrun, underrun_count} !== {(c >= 6), UW'(exp_cnt)}) begin
                errors++;
                $display("FAIL counter c=%0d: ur=%b cnt=%0d expected ur=%b cnt=%0d",
                         c, underrun, underrun_count, (c >= 6), exp_cnt);
            end
        end
        cnt_clr = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if (underrun_count !== UW'(0)) begin
            errors++;
            $display("FAIL counter_clr: cnt=%0d expected 0", underrun_count);
        end
    endtask

    task automatic test_flush();
        pair_t e;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive_pair(1000 + i, -1000 - i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        enable = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({data0, data1, running, bus.in_ready} !== {MIDSCALE, MIDSCALE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_idle: d0=%h d1=%h run=%b rdy=%b expected 2000 2000 0 0",
                     data0, data1, running, bus.in_ready);
        end
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_pair(-300 + 7 * i, 300 - 7 * i);
            @(negedge clk);
            checks++;
            if (running !== (i == 3)) begin
                errors++;
                $display("FAIL flush_reprime push %0d: running=%b expected %b", i, running, (i == 3));
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if ({data0, data1} !== {e.d0, e.d1}) begin
                    errors++;
                    $display("FAIL flush_data c=%0d: got %h/%h expected %h/%h", c, data0, data1, e.d0, e.d1);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_async_reset();
        pair_t e;
        do_reset();
        enter_run(100);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({data0, data1} !== {e.d0, e.d1}) begin
            errors++;
            $display("FAIL areset_pre: got %h/%h expected %h/%h", data0, data1, e.d0, e.d1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data0, data1, underrun, running, bus.in_ready} !== {MIDSCALE, MIDSCALE, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset: d0=%h d1=%h ur=%b run=%b rdy=%b expected 2000 2000 0 0 0",
                     data0, data1, underrun, running, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({running, bus.in_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL areset_reprime: run=%b rdy=%b expected 0 1", running, bus.in_ready);
        end
        enable = 1'b0;
        exp_q.delete();
    endtask

`ifdef DAC_FEED_PATTERN_EN
    task automatic test_pattern();
        pair_t e;
        logic [13:0] r;
        do_reset();
        pattern_sel = 1'b1;
        enter_run(-50);
        for (int c = 1; c <= 8194; c++) begin
            @(negedge clk);
            r = 14'(2 * (c - 1));
            checks++;
            if ({data0, data1, underrun} !== {r, r + 14'd1, 1'b0}) begin
                errors++;
                $display("FAIL pattern c=%0d: got %h/%h ur=%b expected %h/%h ur=0",
                         c, data0, data1, underrun, r, r + 14'd1);
            end
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pattern_nopop: in_ready=%b expected 0", bus.in_ready);
        end
        pattern_sel = 1'b0;
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({data0, data1} !== {e.d0, e.d1}) begin
            errors++;
            $display("FAIL pattern_resume: got %h/%h expected %h/%h", data0, data1, e.d0, e.d1);
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_d0    = '0;
        bus.in_d1    = '0;
        test_reset();
        test_stream();
        test_underrun();
        test_counter();
        test_flush();
        test_async_reset();
`ifdef DAC_FEED_PATTERN_EN
        test_pattern();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
